// File: rtl/cafe_pkg.sv
// Shared constants for the coffee vendor: coin codes and values, FSM states, default price table.
// Pure declarations, no logic.
package cafe_pkg;

    localparam logic [1:0] COIN_100 = 2'b00;
    localparam logic [1:0] COIN_500 = 2'b01;

    localparam int COIN_VAL_100 = 100;
    localparam int COIN_VAL_500 = 500;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam int unsigned DEF_PRICES [4] = '{300, 400, 500, 600};

endpackage

// File: rtl/cafe_coin_decode.sv
// Coin code to value decoder; purely combinational, no backpressure.
// Codes 10/11 decode as invalid with a zero value.
module cafe_coin_decode
    import cafe_pkg::*;
#(
    parameter int CREDIT_W = 12
) (
    input  logic [1:0]          coin_sel,
    output logic [CREDIT_W-1:0] coin_value,
    output logic                coin_ok
);

    always_comb begin
        coin_value = '0;
        coin_ok    = 1'b0;
        case (coin_sel)
            COIN_100: begin
                coin_value = CREDIT_W'(COIN_VAL_100);
                coin_ok    = 1'b1;
            end
            COIN_500: begin
                coin_value = CREDIT_W'(COIN_VAL_500);
                coin_ok    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cafe_vendor.sv
// Coffee vending controller: credit accumulation, product dispense handshake, change return.
// Registered outputs update one cycle after the strobe; dispense_valid holds until dispense_done.
module cafe_vendor
    import cafe_pkg::*;
#(
    parameter int          N_PROD     = 4,
    parameter int          CREDIT_W   = 12,
    parameter int          MAX_CREDIT = 2000,
    parameter int unsigned PRICES [N_PROD] = DEF_PRICES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coin_valid,
    input  logic [1:0]                coin_sel,
    input  logic                      prod_req,
    input  logic [$clog2(N_PROD)-1:0] prod_sel,
    input  logic                      cancel,
    input  logic                      dispense_done,
    output logic [CREDIT_W-1:0]       credit,
    output logic [3:0]                s,
    output logic                      dispense_valid,
    output logic [$clog2(N_PROD)-1:0] dispense_sel,
    output logic                      change_valid,
    output logic [CREDIT_W-1:0]       change_amt,
    output logic                      coin_reject,
    output logic                      deny
);

    state_t               state;
    logic [CREDIT_W-1:0]  coin_value;
    logic                 coin_ok;
    logic [CREDIT_W:0]    sum;
    logic                 fits;
    logic [CREDIT_W-1:0]  price;
    logic                 sel_ok;
    logic [CREDIT_W-1:0]  hundreds;

    cafe_coin_decode #(.CREDIT_W(CREDIT_W)) u_coin_decode (
        .coin_sel   (coin_sel),
        .coin_value (coin_value),
        .coin_ok    (coin_ok)
    );

    // One extra bit so an over-ceiling sum is detected instead of wrapping.
    assign sum  = {1'b0, credit} + {1'b0, coin_value};
    assign fits = sum <= (CREDIT_W+1)'(MAX_CREDIT);

    assign sel_ok = int'(prod_sel) < N_PROD;

    always_comb begin
        price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (int'(prod_sel) == i) price = CREDIT_W'(PRICES[i]);
        end
    end

    assign hundreds = credit / CREDIT_W'(100);
    assign s        = (hundreds > CREDIT_W'(15)) ? 4'd15 : hundreds[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            credit         <= '0;
            dispense_valid <= 1'b0;
            dispense_sel   <= '0;
            change_valid   <= 1'b0;
            change_amt     <= '0;
            coin_reject    <= 1'b0;
            deny           <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            case (state)
                ST_IDLE, ST_CREDIT: begin
                    if (cancel && state == ST_CREDIT) begin
                        state        <= ST_CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                        credit       <= '0;
                        coin_reject  <= coin_valid;
                    end else if (prod_req && sel_ok && credit >= price) begin
                        state          <= ST_DISPENSE;
                        credit         <= credit - price;
                        dispense_valid <= 1'b1;
                        dispense_sel   <= prod_sel;
                        coin_reject    <= coin_valid;
                    end else begin
                        deny <= prod_req;
                        if (coin_valid) begin
                            if (coin_ok && fits) begin
                                credit <= sum[CREDIT_W-1:0];
                                state  <= ST_CREDIT;
                            end else begin
                                coin_reject <= 1'b1;
                            end
                        end
                    end
                end
                ST_DISPENSE: begin
                    coin_reject <= coin_valid;
                    deny        <= cancel;
                    if (dispense_done) begin
                        dispense_valid <= 1'b0;
                        if (credit != '0) begin
                            state        <= ST_CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= credit;
                            credit       <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= coin_valid;
                    deny        <= cancel;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cafe_vendor.md
CAFE_VENDOR -- requirements
Module: cafe_vendor

Interface
REQ-001 Parameter N_PROD, default 4: number of selectable products, range 2..8.
REQ-002 Parameter CREDIT_W, default 12: credit register width, in colones.
REQ-003 Parameter MAX_CREDIT, default 2000: credit ceiling; must fit in CREDIT_W.
REQ-004 Parameter PRICES, default {300,400,500,600}: per-product price array, N_PROD entries of CREDIT_W bits.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 coin_valid  in  1  one-cycle coin-inserted strobe.
REQ-008 coin_sel  in  2  coin code: 00=100, 01=500, 10/11 invalid.
REQ-009 prod_req  in  1  one-cycle product request strobe.
REQ-010 prod_sel  in  $clog2(N_PROD)  requested product index.
REQ-011 cancel  in  1  one-cycle refund request strobe.
REQ-012 dispense_done  in  1  dispenser acknowledge.
REQ-013 credit  out  CREDIT_W  current credit.
REQ-014 s  out  4  display digit: credit/100, saturated at 15.
REQ-015 dispense_valid  out  1  dispense command, held until acknowledged.
REQ-016 dispense_sel  out  $clog2(N_PROD)  product being dispensed.
REQ-017 change_valid  out  1  one-cycle change-return pulse.
REQ-018 change_amt  out  CREDIT_W  change value; valid only with change_valid, else 0.
REQ-019 coin_reject  out  1  one-cycle pulse: coin returned.
REQ-020 deny  out  1  one-cycle pulse: request refused.

Function
REQ-021 States SHALL be IDLE (credit=0), CREDIT (credit>0), DISPENSE and CHANGE.
REQ-022 In IDLE/CREDIT, a valid coin with credit+value <= MAX_CREDIT SHALL add its value next cycle and enter or stay in CREDIT.
REQ-023 An invalid coin_sel, overflow past MAX_CREDIT, or any coin in DISPENSE/CHANGE SHALL pulse coin_reject next cycle with credit unchanged.
REQ-024 In IDLE/CREDIT, prod_req with prod_sel < N_PROD and credit >= PRICES[prod_sel] SHALL, next cycle, subtract the price, enter DISPENSE, assert dispense_valid and latch dispense_sel.
REQ-025 prod_req with insufficient credit or prod_sel >= N_PROD SHALL pulse deny next cycle; credit and state unchanged.
REQ-026 dispense_valid SHALL stay high until the cycle dispense_done is sampled high; dispense_done is ignored outside DISPENSE.
REQ-027 On dispense_done: remaining credit > 0 -> CHANGE; remaining credit = 0 -> IDLE.
REQ-028 CHANGE SHALL last exactly one cycle: change_valid=1, change_amt=credit, credit cleared, next state IDLE.
REQ-029 cancel in CREDIT SHALL enter CHANGE next cycle; cancel in IDLE SHALL be ignored; cancel in DISPENSE/CHANGE SHALL pulse deny.
REQ-030 Same-cycle priority in IDLE/CREDIT: cancel > prod_req > coin; a lower-priority prod_req SHALL be ignored, and a coin coinciding with an accepted cancel or prod_req SHALL be rejected.
REQ-031 s SHALL track credit combinationally; all other outputs SHALL be registered.
REQ-032 Credit arithmetic SHALL never wrap; credit <= MAX_CREDIT at all times.

Reset
REQ-033 While reset is high: state IDLE, credit=0, s=0, all valid/pulse outputs 0, dispense_sel=0, change_amt=0.
REQ-034 Reset asserted mid-DISPENSE or mid-CHANGE SHALL drop dispense_valid/change_valid immediately and discard credit without change.

Structure
REQ-035 Package cafe_pkg SHALL hold the coin-code constants, coin values (100, 500), the state enum and the default price table.
REQ-036 One sub-module, cafe_coin_decode, SHALL map coin_sel to a value and a valid flag.

Verification
REQ-037 Coins 100,100,100, then prod_req sel=0 -> credit 300, dispense_valid; after dispense_done -> IDLE, no change pulse.
REQ-038 Coin 500, prod_req sel=1, dispense_done -> change_valid with change_amt=100, credit 0.
REQ-039 Coin 100, prod_req sel=3 -> deny pulse, credit stays 100; then cancel -> change_amt=100.
REQ-040 Four coins of 500, then one of 100 -> last coin rejected, credit 2000, s=15.
REQ-041 Coin and prod_req in the same cycle with credit 300, sel=0 -> dispense, coin_reject; coin_sel=11 -> coin_reject.
REQ-042 Reset pulse while dispense_valid is high -> all outputs 0 asynchronously, state IDLE.
